// File: rtl/ofdm_cp_framer_if.sv
// rtl/ofdm_cp_framer_if.sv - sample-stream handshake bundle for the cyclic-prefix framer
// Purpose: groups the input sample stream (s_*) and the extended-symbol output stream (m_*).
// Ports (signals):
//   s_tdata/s_tvalid/s_tlast -> framer, s_tready <- framer
//   m_tdata/m_tvalid/m_tuser/m_tlast <- framer, m_tready -> framer
// Modports: master = surrounding logic (source of s_*, sink of m_*), slave = framer.
interface ofdm_cp_framer_if #(
  parameter int W = 16
);
  logic [W-1:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tuser;
  logic         m_tlast;

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tuser, m_tlast
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tuser, m_tlast
  );
endinterface

// File: rtl/ofdm_cp_framer.sv
// rtl/ofdm_cp_framer.sv - ping-pong buffered cyclic-prefix inserter for OFDM symbols
// Purpose: stores N-sample IFFT symbols in two banks and re-emits each one as
//   CP+N samples (last CP samples, then all N), or N samples when bypassed.
// Ports:
//   aclk        clock
//   reset       synchronous active-high reset
//   bypass      suppress the prefix; sampled when a symbol starts
//   s           stream bundle (slave modport): s_* input samples, m_* output samples
//   err_framing one-cycle pulse when s_tlast disagrees with the sample count
//   sym_count   number of completed output symbols (wraps)
module ofdm_cp_framer #(
  parameter int N  = 8,
  parameter int CP = 2,
  parameter int W  = 16
) (
  input  logic            aclk,
  input  logic            reset,
  input  logic            bypass,
  ofdm_cp_framer_if.slave s,
  output logic            err_framing,
  output logic [15:0]     sym_count
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [IW-1:0] PRE_START = IW'(N - CP);
  localparam bit            HAS_CP    = (CP > 0);

  typedef enum logic [1:0] {IDLE, PREFIX, BODY} state_t;

  state_t        state, state_n;
  logic [W-1:0]  mem [2][N];
  logic [1:0]    full;
  logic          wr_bank;
  logic [IW-1:0] wr_idx;
  logic          rd_bank, rd_bank_n;
  logic [IW-1:0] rd_idx, rd_idx_n;
  logic          byp_lat, byp_lat_n;

  logic          in_hs;
  logic          wr_last;
  logic          have;
  logic          in_prefix;
  logic          first;
  logic          out_ld;
  logic          last_body;
  logic          free_bank;
  logic [IW-1:0] cur_idx;

  // Write side: a bank is writable whenever its full flag is clear.
  assign s.s_tready = !full[wr_bank];
  assign in_hs      = s.s_tvalid && s.s_tready;
  assign wr_last    = (wr_idx == LAST_IDX);

  // Read FSM. The first sample of a symbol is fetched straight out of IDLE
  // so the output register loads on the same edge the start is detected;
  // this keeps the fill-to-output latency at one cycle and leaves no bubble
  // between back-to-back symbols.
  always_comb begin
    state_n   = state;
    rd_idx_n  = rd_idx;
    rd_bank_n = rd_bank;
    byp_lat_n = byp_lat;
    have      = 1'b0;
    in_prefix = 1'b0;
    first     = 1'b0;
    cur_idx   = rd_idx;
    free_bank = 1'b0;

    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          have  = 1'b1;
          first = 1'b1;
          if (HAS_CP && !bypass) begin
            in_prefix = 1'b1;
            cur_idx   = PRE_START;
          end else begin
            cur_idx   = '0;
          end
        end
      end
      PREFIX: begin
        have      = 1'b1;
        in_prefix = 1'b1;
      end
      BODY: begin
        have = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    out_ld    = have && (!s.m_tvalid || s.m_tready);
    last_body = !in_prefix && (cur_idx == LAST_IDX);

    if (out_ld) begin
      if (first) begin
        byp_lat_n = bypass;
      end
      if (cur_idx == LAST_IDX) begin
        rd_idx_n = '0;
        if (in_prefix) begin
          state_n = BODY;
        end else begin
          // Symbol done: release the bank; IDLE restarts immediately next
          // cycle if the other bank is already full.
          state_n   = IDLE;
          free_bank = 1'b1;
          rd_bank_n = !rd_bank;
        end
      end else begin
        rd_idx_n = cur_idx + 1'b1;
        state_n  = in_prefix ? PREFIX : BODY;
      end
    end
  end

  // Sample storage carries no reset; contents are only read after a fill.
  always_ff @(posedge aclk) begin
    if (in_hs) begin
      mem[wr_bank][wr_idx] <= s.s_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state       <= IDLE;
      full        <= '0;
      wr_bank     <= 1'b0;
      wr_idx      <= '0;
      rd_bank     <= 1'b0;
      rd_idx      <= '0;
      byp_lat     <= 1'b0;
      s.m_tdata   <= '0;
      s.m_tvalid  <= 1'b0;
      s.m_tuser   <= 1'b0;
      s.m_tlast   <= 1'b0;
      err_framing <= 1'b0;
      sym_count   <= '0;
    end else begin
      state   <= state_n;
      rd_idx  <= rd_idx_n;
      rd_bank <= rd_bank_n;
      byp_lat <= byp_lat_n;

      // Free and fill always target different banks, so both may land
      // on the same edge.
      if (free_bank) begin
        full[rd_bank] <= 1'b0;
      end
      if (in_hs && wr_last) begin
        full[wr_bank] <= 1'b1;
      end

      if (in_hs) begin
        wr_idx  <= wr_last ? '0 : wr_idx + 1'b1;
        wr_bank <= wr_last ? !wr_bank : wr_bank;
      end

      err_framing <= in_hs && (s.s_tlast != wr_last);

      if (out_ld) begin
        s.m_tdata  <= mem[rd_bank][cur_idx];
        s.m_tvalid <= 1'b1;
        s.m_tuser  <= first;
        s.m_tlast  <= last_body;
      end else if (s.m_tready) begin
        s.m_tvalid <= 1'b0;
      end

      if (s.m_tvalid && s.m_tready && s.m_tlast) begin
        sym_count <= sym_count + 16'd1;
      end
    end
  end

  // A prefix is only ever emitted for a symbol that started un-bypassed.
  assert property (@(posedge aclk) disable iff (reset) (state == PREFIX) |-> !byp_lat);

endmodule
